// File: rtl/sdr_pkg.sv
// Shared definitions for the SDRAM bank monitor.
// Holds the command encodings, bank-state and error enums, and burst-length decode.
package sdr_pkg;

   localparam int CNT_W = 8;
   localparam logic [2:0] BL_CODE_RST = 3'b011;
   localparam logic [2:0] BL_CODE_FULL = 3'b111;

   // {cs_n, ras_n, cas_n, we_n}
   typedef enum logic [3:0] {
      CMD_LMR = 4'b0000,
      CMD_REF = 4'b0001,
      CMD_PRE = 4'b0010,
      CMD_ACT = 4'b0011,
      CMD_WR  = 4'b0100,
      CMD_RD  = 4'b0101,
      CMD_BST = 4'b0110,
      CMD_NOP = 4'b0111
   } cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE         = 3'b000,
      ST_PRE          = 3'b001,
      ST_ACT          = 3'b010,
      ST_XFR          = 3'b011,
      ST_DMA_LAST_PRE = 3'b100
   } bank_st_e;

   typedef enum logic [2:0] {
      ERR_NONE     = 3'd0,
      ERR_ACT_BUSY = 3'd1,
      ERR_RW_STATE = 3'd2,
      ERR_RW_TRCD  = 3'd3,
      ERR_REF_BUSY = 3'd4,
      ERR_LMR_BUSY = 3'd5
   } err_e;

   // Reserved codes fall back to an 8-beat burst.
   function automatic logic [CNT_W-1:0] bl_len_m1(input logic [2:0] code);
      case (code)
         3'b000:  return CNT_W'(0);
         3'b001:  return CNT_W'(1);
         3'b010:  return CNT_W'(3);
         default: return CNT_W'(7);
      endcase
   endfunction

   function automatic logic bl_is_full(input logic [2:0] code);
      return code == BL_CODE_FULL;
   endfunction

endpackage

// File: rtl/sdr_bank_trk.sv
// Tracks one SDRAM bank: state, open row, tRCD countdown and the shared burst/tRP counter.
// Command strobes arrive pre-qualified by the top level, so no legality checks here.
module sdr_bank_trk
   import sdr_pkg::*;
#(
   parameter int TRCD = 3,
   parameter int TRP  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             act_i,
   input  logic             rw_i,
   input  logic             rw_ap_i,
   input  logic             rw_full_i,
   input  logic [CNT_W-1:0] rw_len_m1_i,
   input  logic             bst_i,
   input  logic             pre_i,
   input  logic [12:0]      row_i,
   output logic [2:0]       st_o,
   output logic [12:0]      row_o,
   output logic             rcd_done_o
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(TRCD - 1);
   localparam logic [CNT_W-1:0] TRP_LOAD = CNT_W'(TRP - 1);

   bank_st_e         st_q, st_d;
   logic [12:0]      row_q, row_d;
   logic [CNT_W-1:0] rcd_q, rcd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             full_q, full_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q   <= ST_IDLE;
         row_q  <= '0;
         rcd_q  <= '0;
         cnt_q  <= '0;
         full_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         row_q  <= row_d;
         rcd_q  <= rcd_d;
         cnt_q  <= cnt_d;
         full_q <= full_d;
      end
   end

   always_comb begin
      st_d   = st_q;
      row_d  = row_q;
      rcd_d  = (rcd_q != '0) ? rcd_q - CNT_ONE : '0;
      cnt_d  = cnt_q;
      full_d = full_q;

      case (st_q)
         ST_XFR: begin
            if (!full_q) begin
               if (cnt_q == '0) st_d = ST_ACT;
               else             cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_DMA_LAST_PRE: begin
            if (!full_q) begin
               if (cnt_q == '0) begin
                  st_d  = ST_PRE;
                  cnt_d = TRP_LOAD;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
         end
         ST_PRE: begin
            if (cnt_q == '0) st_d = ST_IDLE;
            else             cnt_d = cnt_q - CNT_ONE;
         end
         default: ;
      endcase

      // A command on this bank overrides any timer-driven transition in the same cycle.
      if (act_i) begin
         st_d  = ST_ACT;
         row_d = row_i;
         rcd_d = RCD_LOAD;
      end else if (rw_i) begin
         st_d   = rw_ap_i ? ST_DMA_LAST_PRE : ST_XFR;
         cnt_d  = rw_len_m1_i;
         full_d = rw_full_i;
      end else if (pre_i) begin
         st_d   = ST_PRE;
         cnt_d  = TRP_LOAD;
         full_d = 1'b0;
      end else if (bst_i && st_q == ST_XFR) begin
         st_d = ST_ACT;
      end
   end

   assign st_o       = st_q;
   assign row_o      = row_q;
   assign rcd_done_o = (rcd_q == '0);

endmodule

// File: rtl/sdr_bank_monitor.sv
// Passive SDRAM protocol monitor: decodes sampled command pins, tracks four banks,
// and reports the first protocol violation of each command as a one-cycle pulse.
module sdr_bank_monitor
   import sdr_pkg::*;
#(
   parameter int TRCD = 3,
   parameter int TRP  = 3
) (
   input  logic             sdram_clk,
   input  logic             sdram_reset,
   input  logic             sdr_cke,
   input  logic             sdr_cs_n,
   input  logic             sdr_ras_n,
   input  logic             sdr_cas_n,
   input  logic             sdr_we_n,
   input  logic [1:0]       sdr_ba,
   input  logic [12:0]      sdr_addr,
   output logic [3:0][2:0]  bank_st,
   output logic [3:0][12:0] bank_row,
   output logic             err_valid,
   output logic [2:0]       err_code,
   output logic [1:0]       err_bank
);

   cmd_e             cmd;
   logic [3:0]       busy;
   logic [3:0]       rcd_done;
   logic [1:0]       low_busy;
   logic [3:0]       act_s, rw_s, pre_s;
   logic             bst_s;
   logic [2:0]       sel_st;
   err_e             err_d;
   logic [1:0]       eb_d;
   logic [2:0]       bl_code_q, bl_code_d;
   logic             err_valid_q;
   logic [2:0]       err_code_q;
   logic [1:0]       err_bank_q;

   assign cmd = (sdr_cke && !sdr_cs_n) ? cmd_e'({sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n})
                                       : CMD_NOP;

   for (genvar gi = 0; gi < 4; gi++) begin : g_bank
      sdr_bank_trk #(
         .TRCD (TRCD),
         .TRP  (TRP)
      ) u_trk (
         .clk         (sdram_clk),
         .rst         (sdram_reset),
         .act_i       (act_s[gi]),
         .rw_i        (rw_s[gi]),
         .rw_ap_i     (sdr_addr[10]),
         .rw_full_i   (bl_is_full(bl_code_q)),
         .rw_len_m1_i (bl_len_m1(bl_code_q)),
         .bst_i       (bst_s),
         .pre_i       (pre_s[gi]),
         .row_i       (sdr_addr),
         .st_o        (bank_st[gi]),
         .row_o       (bank_row[gi]),
         .rcd_done_o  (rcd_done[gi])
      );
      assign busy[gi] = (bank_st[gi] != ST_IDLE);
   end

   always_comb begin
      low_busy = 2'd0;
      for (int b = 3; b >= 0; b--) begin
         if (busy[b]) low_busy = 2'(b);
      end
   end

   assign sel_st = bank_st[sdr_ba];

   always_comb begin
      err_d     = ERR_NONE;
      eb_d      = sdr_ba;
      act_s     = '0;
      rw_s      = '0;
      pre_s     = '0;
      bst_s     = 1'b0;
      bl_code_d = bl_code_q;

      case (cmd)
         CMD_ACT: begin
            if (sel_st != ST_IDLE) err_d = ERR_ACT_BUSY;
            else                   act_s[sdr_ba] = 1'b1;
         end
         CMD_RD, CMD_WR: begin
            if (sel_st != ST_ACT && sel_st != ST_XFR) err_d = ERR_RW_STATE;
            else if (!rcd_done[sdr_ba])               err_d = ERR_RW_TRCD;
            else                                      rw_s[sdr_ba] = 1'b1;
         end
         CMD_BST: bst_s = 1'b1;
         CMD_PRE: begin
            // Precharging an idle bank is legal and simply ignored.
            if (sdr_addr[10])              pre_s = busy;
            else if (sel_st != ST_IDLE)    pre_s[sdr_ba] = 1'b1;
         end
         CMD_REF: begin
            if (|busy) begin
               err_d = ERR_REF_BUSY;
               eb_d  = low_busy;
            end
         end
         CMD_LMR: begin
            if (|busy) begin
               err_d = ERR_LMR_BUSY;
               eb_d  = low_busy;
            end else begin
               bl_code_d = sdr_addr[2:0];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge sdram_clk or posedge sdram_reset) begin
      if (sdram_reset) begin
         bl_code_q   <= BL_CODE_RST;
         err_valid_q <= 1'b0;
         err_code_q  <= 3'd0;
         err_bank_q  <= 2'd0;
      end else begin
         bl_code_q   <= bl_code_d;
         err_valid_q <= (err_d != ERR_NONE);
         err_code_q  <= err_d;
         err_bank_q  <= (err_d != ERR_NONE) ? eb_d : 2'd0;
      end
   end

   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;
   assign err_bank  = err_bank_q;

endmodule
